// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE operand-loading path.
package pe_pkg;

    typedef enum logic {FILL, HOLD} loader_state_t;

    function automatic int slot_lsb(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/pe_vec_loader_if.sv
// Word stream in, assembled vector out; slave is the loader side.
interface pe_vec_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 33
);
    localparam int CNT_WIDTH = $clog2(DATA_DEPTH + 1);

    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_last;
    logic                             vec_valid;
    logic                             vec_ready;
    logic [DATA_DEPTH*DATA_WIDTH-1:0] vec_data;
    logic [CNT_WIDTH-1:0]             vec_count;

    modport master (
        output in_valid, in_data, in_last, vec_ready,
        input  in_ready, vec_valid, vec_data, vec_count
    );

    modport slave (
        input  in_valid, in_data, in_last, vec_ready,
        output in_ready, vec_valid, vec_data, vec_count
    );

endinterface

// File: rtl/pe_demux.sv
// 1-to-N word demux: the selected slot carries data_in when enabled, all others zero.
module pe_demux
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLOTS  = 33,
    parameter int SEL_WIDTH  = $clog2(NUM_SLOTS)
) (
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic                            en,
    output logic [NUM_SLOTS*DATA_WIDTH-1:0] data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (en && (sel == SEL_WIDTH'(i)))
                data_out[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = data_in;
        end
    end

endmodule

// File: rtl/pe_vec_loader.sv
// Serial-to-parallel operand loader: fills a register bank word by word, then
// holds the flat vector until the PE datapath takes it.
module pe_vec_loader
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 33,
    parameter int SEL_WIDTH  = $clog2(DATA_DEPTH),
    parameter int CNT_WIDTH  = $clog2(DATA_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    pe_vec_loader_if.slave  bus
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(DATA_DEPTH - 1);

    loader_state_t                    state;
    loader_state_t                    state_nxt;
    logic [SEL_WIDTH-1:0]             wr_idx;
    logic [CNT_WIDTH-1:0]             vec_count;
    logic [DATA_DEPTH*DATA_WIDTH-1:0] bank;
    logic [DATA_DEPTH*DATA_WIDTH-1:0] wr_data;
    logic [DATA_DEPTH-1:0]            wr_en;
    logic                             in_rdy;
    logic                             vec_vld;
    logic                             in_hs;
    logic                             last_word;

    assign in_hs     = bus.in_valid & in_rdy;
    assign last_word = (wr_idx == LAST_IDX) || bus.in_last;

    pe_demux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (DATA_DEPTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_demux (
        .data_in  (bus.in_data),
        .sel      (wr_idx),
        .en       (in_hs),
        .data_out (wr_data)
    );

    for (genvar i = 0; i < DATA_DEPTH; i++) begin : g_wr_en
        assign wr_en[i] = in_hs && (wr_idx == SEL_WIDTH'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Handshake outputs decode from state alone, so no input reaches them combinationally.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        vec_vld   = 1'b0;
        case (state)
            FILL: begin
                in_rdy = 1'b1;
                if (bus.in_valid && last_word) state_nxt = HOLD;
            end
            HOLD: begin
                vec_vld = 1'b1;
                if (bus.vec_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
        if (clear) state_nxt = FILL;
    end

    // Bank is zeroed on every vector exit so slots past a short vector read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx    <= '0;
            vec_count <= '0;
            bank      <= '0;
        end else if (clear) begin
            wr_idx    <= '0;
            vec_count <= '0;
            bank      <= '0;
        end else if (in_hs) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                if (wr_en[i])
                    bank[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <=
                        wr_data[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end
            if (last_word) begin
                vec_count <= CNT_WIDTH'(wr_idx) + CNT_WIDTH'(1);
                wr_idx    <= '0;
            end else begin
                wr_idx    <= wr_idx + SEL_WIDTH'(1);
            end
        end else if (vec_vld && bus.vec_ready) begin
            vec_count <= '0;
            bank      <= '0;
        end
    end

    if (DATA_DEPTH < (1 << SEL_WIDTH)) begin : g_idx_chk
        a_wr_idx_range: assert property (@(posedge clk) disable iff (!rst_n) wr_idx <= LAST_IDX);
    end

    assign bus.in_ready  = in_rdy;
    assign bus.vec_valid = vec_vld;
    assign bus.vec_data  = bank;
    assign bus.vec_count = vec_count;

endmodule

// File: tb/tb_pe_vec_loader.sv
// Directed bench for pe_vec_loader: a 33x8 instance and a 4x16 instance.
module tb_pe_vec_loader;

    localparam int AW = 8;
    localparam int AD = 33;
    localparam int BW = 16;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_cmp = 0;
    int   n_err = 0;

    pe_vec_loader_if #(.DATA_WIDTH(AW), .DATA_DEPTH(AD)) ifa ();
    pe_vec_loader_if #(.DATA_WIDTH(BW), .DATA_DEPTH(BD)) ifb ();

    pe_vec_loader #(.DATA_WIDTH(AW), .DATA_DEPTH(AD)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (ifa.slave)
    );

    pe_vec_loader #(.DATA_WIDTH(BW), .DATA_DEPTH(BD)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slots 0..n-1 hold base, base+1, ...; remaining slots zero.
    function automatic logic [511:0] exp_a(input int n, input logic [7:0] base);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*AW +: AW] = base + 8'(i);
        return v;
    endfunction

    task automatic send_a(input logic [AW-1:0] d, input logic last);
        int w;
        w = 0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        ifa.in_last  = last;
        @(negedge clk);
        while (!ifa.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ifa.in_ready) chk("a_in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [BW-1:0] d, input logic last);
        int w;
        w = 0;
        ifb.in_valid = 1'b1;
        ifb.in_data  = d;
        ifb.in_last  = last;
        @(negedge clk);
        while (!ifb.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ifb.in_ready) chk("b_in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.in_last   = 1'b0;
        ifa.vec_ready = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.in_data   = '0;
        ifb.in_last   = 1'b0;
        ifb.vec_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_vec_valid", ifa.vec_valid, 0);
        chk("rst_vec_count", ifa.vec_count, 0);
        chk("rst_in_ready",  ifa.in_ready,  1);
        chk("rst_vec_data",  ifa.vec_data,  0);
        @(posedge clk); #1;

        // Full load 0x01..0x21, consumer always ready
        ifa.vec_ready = 1'b1;
        for (int i = 0; i < AD; i++) send_a(8'(i + 1), 1'b0);
        chk("full_vec_valid", ifa.vec_valid, 1);
        chk("full_vec_data",  ifa.vec_data,  exp_a(33, 8'h01));
        chk("full_vec_count", ifa.vec_count, 33);
        chk("full_in_ready_hold", ifa.in_ready, 0);
        @(posedge clk); #1;
        chk("full_vec_valid_after", ifa.vec_valid, 0);
        chk("full_in_ready_after",  ifa.in_ready,  1);
        chk("full_bank_cleared",    ifa.vec_data,  0);
        chk("full_count_cleared",   ifa.vec_count, 0);

        // Prior vector of 0xFF, then a short vector A0..A4
        for (int i = 0; i < AD; i++) send_a(8'hFF, 1'b0);
        @(posedge clk); #1;
        ifa.vec_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_a(8'hA0 + 8'(i), i == 4);
        chk("short_vec_valid", ifa.vec_valid, 1);
        chk("short_vec_count", ifa.vec_count, 5);
        chk("short_vec_data",  ifa.vec_data,  exp_a(5, 8'hA0));

        // Held vector stays put under backpressure, offered words are refused
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'h55;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_vec_valid", ifa.vec_valid, 1);
            chk("bp_in_ready",  ifa.in_ready,  0);
            chk("bp_vec_data",  ifa.vec_data,  exp_a(5, 8'hA0));
            chk("bp_vec_count", ifa.vec_count, 5);
        end
        ifa.in_valid  = 1'b0;
        ifa.vec_ready = 1'b1;
        @(posedge clk); #1;
        ifa.vec_ready = 1'b0;
        chk("bp_release_valid", ifa.vec_valid, 0);

        // Gapped input: idle cycle after every odd word
        for (int i = 0; i < 8; i++) begin
            send_a(8'h30 + 8'(i), i == 7);
            if (i % 2 == 1 && i != 7) begin
                @(posedge clk); #1;
            end
        end
        chk("gap_vec_count", ifa.vec_count, 8);
        chk("gap_vec_data",  ifa.vec_data,  exp_a(8, 8'h30));
        ifa.vec_ready = 1'b1;
        @(posedge clk); #1;
        ifa.vec_ready = 1'b0;
        chk("gap_release_valid", ifa.vec_valid, 0);

        // Clear after 12 words, with a concurrent input word that must be dropped
        for (int i = 0; i < 12; i++) send_a(8'h10 + 8'(i), 1'b0);
        clear        = 1'b1;
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'hEE;
        @(posedge clk); #1;
        clear        = 1'b0;
        ifa.in_valid = 1'b0;
        chk("clr_fill_in_ready", ifa.in_ready,  1);
        chk("clr_fill_data",     ifa.vec_data,  0);
        chk("clr_fill_count",    ifa.vec_count, 0);
        for (int i = 0; i < AD; i++) send_a(8'h40 + 8'(i), 1'b0);
        chk("clr_new_valid", ifa.vec_valid, 1);
        chk("clr_new_count", ifa.vec_count, 33);
        chk("clr_new_data",  ifa.vec_data,  exp_a(33, 8'h40));

        // Clear together with the vector handshake in HOLD
        clear         = 1'b1;
        ifa.vec_ready = 1'b1;
        @(posedge clk); #1;
        clear         = 1'b0;
        ifa.vec_ready = 1'b0;
        chk("clr_hold_valid",    ifa.vec_valid, 0);
        chk("clr_hold_in_ready", ifa.in_ready,  1);
        chk("clr_hold_data",     ifa.vec_data,  0);
        chk("clr_hold_count",    ifa.vec_count, 0);
        send_a(8'h77, 1'b1);
        chk("one_word_count", ifa.vec_count, 1);
        chk("one_word_data",  ifa.vec_data,  exp_a(1, 8'h77));

        // Asynchronous reset while holding: takes effect between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vec_valid", ifa.vec_valid, 0);
        chk("arst_vec_data",  ifa.vec_data,  0);
        chk("arst_vec_count", ifa.vec_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", ifa.in_ready, 1);

        // Full load on the 4 x 16 instance
        ifb.vec_ready = 1'b1;
        for (int i = 0; i < BD; i++) send_b(16'(i + 1), 1'b0);
        chk("b_full_valid", ifb.vec_valid, 1);
        chk("b_full_data",  ifb.vec_data,  64'h0004_0003_0002_0001);
        chk("b_full_count", ifb.vec_count, 4);
        @(posedge clk); #1;
        chk("b_after_valid",    ifb.vec_valid, 0);
        chk("b_after_in_ready", ifb.in_ready,  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
